// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - Receive-side signal bundle for the UART receiver
//
// Purpose: groups the serial line, enable and received-byte handshake of
// uart_rx so the receiver and its consumer share one connection.
// Signals:
//   rx_en   enable; low holds the receiver idle
//   rx_in   asynchronous serial line, idles high
//   rx_out  last received byte
//   rx_done one-cycle pulse when a frame completes
//   rx_busy frame in progress
//   rx_err  stop bit sampled low; pulses with rx_done
// Modports: slave = the receiver, master = the driver/consumer side.

interface uart_rx_if;
  logic       rx_en;
  logic       rx_in;
  logic [7:0] rx_out;
  logic       rx_done;
  logic       rx_busy;
  logic       rx_err;

  modport slave (
    input  rx_en,
    input  rx_in,
    output rx_out,
    output rx_done,
    output rx_busy,
    output rx_err
  );

  modport master (
    output rx_en,
    output rx_in,
    input  rx_out,
    input  rx_done,
    input  rx_busy,
    input  rx_err
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, 16 clocks per bit, LSB first
//
// Purpose: synchronizes the serial line, detects a start bit, samples eight
// data bits and the stop bit mid-bit, and presents each byte with a
// one-cycle done pulse. A low stop bit raises rx_err with rx_done and the
// receiver then waits for the line to return high before looking for the
// next start bit.
// Ports:
//   rx_clk    clock, rising edge
//   rx_rst_n  asynchronous active-low reset
//   bus       uart_rx_if.slave (rx_en, rx_in, rx_out, rx_done, rx_busy, rx_err)
// Parameters: CLOCK_RATE, BAUD_RATE are informational only.
// Build option: UART_RX_MAJORITY_EN makes every sample the 2-of-3 majority
//   of the synchronized line over the decision clock and the two before it.

module uart_rx #(
  parameter int CLOCK_RATE = 10,
  parameter int BAUD_RATE  = 9600
) (
  input logic      rx_clk,
  input logic      rx_rst_n,
  uart_rx_if.slave bus
);

  if (CLOCK_RATE < 1 || BAUD_RATE < 1) begin : g_bad_cfg
    $error("uart_rx: CLOCK_RATE and BAUD_RATE must be positive");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'b001,
    START_BIT = 3'b010,
    DATA_BIT  = 3'b011,
    STOP_BIT  = 3'b100,
    CLEANUP   = 3'b101
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] clk_cnt, clk_cnt_nxt;
  logic [2:0] bit_idx, bit_idx_nxt;
  logic [7:0] shift_q, shift_nxt;
  logic [7:0] out_q, out_nxt;
  logic       done_q, done_nxt;
  logic       busy_q, busy_nxt;
  logic       err_q, err_nxt;
  logic       sync1, rx_s;
  logic       sample;

`ifdef UART_RX_MAJORITY_EN
  // rx_s delayed by one and two clocks: at a decision point these hold the
  // values from clockCount-1 and clockCount-2 without tracking the count.
  logic hist1, hist2;
  assign sample = (rx_s & hist1) | (rx_s & hist2) | (hist1 & hist2);
`else
  assign sample = rx_s;
`endif

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift_q;
    out_nxt     = out_q;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    busy_nxt    = busy_q;

    if (!bus.rx_en) begin
      state_nxt   = IDLE;
      clk_cnt_nxt = 4'd0;
      bit_idx_nxt = 3'd0;
      busy_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clk_cnt_nxt = 4'd0;
          bit_idx_nxt = 3'd0;
          if (!rx_s) begin
            state_nxt = START_BIT;
            busy_nxt  = 1'b1;
          end
        end

        START_BIT: begin
          if (clk_cnt == 4'd7) begin
            clk_cnt_nxt = 4'd0;
            if (sample) begin
              // Line went back high before mid-bit: not a real start bit.
              state_nxt = IDLE;
              busy_nxt  = 1'b0;
            end else begin
              state_nxt = DATA_BIT;
            end
          end else begin
            clk_cnt_nxt = clk_cnt + 4'd1;
          end
        end

        DATA_BIT: begin
          // clockCount wraps 15 -> 0 on its own, which restarts the bit.
          clk_cnt_nxt = clk_cnt + 4'd1;
          if (clk_cnt == 4'd15) begin
            shift_nxt[bit_idx] = sample;
            bit_idx_nxt        = bit_idx + 3'd1;
            if (bit_idx == 3'd7) state_nxt = STOP_BIT;
          end
        end

        STOP_BIT: begin
          clk_cnt_nxt = clk_cnt + 4'd1;
          if (clk_cnt == 4'd15) begin
            out_nxt   = shift_q;
            done_nxt  = 1'b1;
            err_nxt   = ~sample;
            busy_nxt  = 1'b0;
            state_nxt = sample ? IDLE : CLEANUP;
          end
        end

        CLEANUP: begin
          // A low stop bit means the line may still be held low (break);
          // wait for it to go high so the low level is not read as a start.
          clk_cnt_nxt = 4'd0;
          if (rx_s) state_nxt = IDLE;
        end

        default: begin
          state_nxt   = IDLE;
          clk_cnt_nxt = 4'd0;
          bit_idx_nxt = 3'd0;
          busy_nxt    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      state   <= IDLE;
      clk_cnt <= 4'd0;
      bit_idx <= 3'd0;
      shift_q <= 8'h00;
      out_q   <= 8'h00;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1   <= bus.rx_in;
      rx_s    <= sync1;
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift_q <= shift_nxt;
      out_q   <= out_nxt;
      done_q  <= done_nxt;
      busy_q  <= busy_nxt;
      err_q   <= err_nxt;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      hist1 <= 1'b1;
      hist2 <= 1'b1;
    end else begin
      hist1 <= rx_s;
      hist2 <= hist1;
    end
  end
`endif

  assign bus.rx_out  = out_q;
  assign bus.rx_done = done_q;
  assign bus.rx_busy = busy_q;
  assign bus.rx_err  = err_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART block, directly downstream of the UART transmitter. It samples an asynchronous 8N1 line at 16 clocks per bit and reconstructs 8-bit bytes, LSB first. It flags stop-bit framing errors and hands each byte to the consumer with a one-cycle done pulse. Bit timing matches the transmitter: 16 clock cycles per bit on the same clock domain rate.

## Interface
- CLOCK_RATE, 10: informational only; no effect on logic
- BAUD_RATE, 9600: informational only; no effect on logic
- IDLE, 3'b001: state encoding
- START_BIT, 3'b010: state encoding
- DATA_BIT, 3'b011: state encoding
- STOP_BIT, 3'b100: state encoding
- CLEANUP, 3'b101: state encoding; waits for the line to go high after a framing error
- rx_clk  in  1  clock, rising edge
- rx_rst_n  in  1  reset; asynchronous, active-low
- rx_en  in  1  synchronous enable; low forces IDLE
- rx_in  in  1  serial line, asynchronous, idles high
- rx_out  out  8  last received byte; held until the next frame completes
- rx_done  out  1  one-cycle pulse when a frame completes
- rx_busy  out  1  frame in progress
- rx_err  out  1  framing error (stop bit sampled low); pulses together with rx_done

## Operation
- rx_in passes through a 2-flop synchronizer; the output is rx_s. Both flops reset to 1.
- Internal registers:
  - 4-bit clockCount, wraps 15→0
  - 3-bit bitIdx
  - 8-bit shift register
- IDLE:
  - clockCount=0, bitIdx=0
  - rx_s==0 → START_BIT; rx_busy←1
- START_BIT:
  - At clockCount==7, sample the line.
  - Sample 1 → false start: IDLE, rx_busy←0, no rx_done.
  - Sample 0 → DATA_BIT, clockCount←0.
- DATA_BIT:
  - At clockCount==15, shift[bitIdx]←sample, clockCount←0, bitIdx+1.
  - After bitIdx 7 → STOP_BIT.
- STOP_BIT:
  - At clockCount==15: rx_out←shift, rx_done←1, rx_err←~sample, rx_busy←0.
  - Sample 1 → IDLE. Sample 0 → CLEANUP.
- CLEANUP: rx_s==1 → IDLE. Start detection is suppressed until then.
- rx_done and rx_err are high for exactly one cycle, then return to 0.
- rx_en low, synchronous:
  - State→IDLE; rx_busy, rx_done, rx_err←0.
  - rx_out is held; the synchronizer keeps running.
- Undefined state encoding → IDLE.
- Reset values: state=IDLE, rx_out=8'h00, rx_done=0, rx_busy=0, rx_err=0, clockCount=0, bitIdx=0.

## Timing
- Let E0 be the first rx_clk edge that captures rx_in low.
  - E1: rx_s=0.
  - E2: enter START_BIT; rx_busy high after E2.
  - E10: start-bit check.
  - Data bit i is sampled at E26+16·i (bit 7 at E138).
  - E154: stop sample; rx_done, rx_err, and the new rx_out are visible in the cycle after E154.
- Samples fall about 8 clocks into each bit, i.e. mid-bit.
- A false start releases rx_busy after E10.
- Back-to-back frames with no idle gap are supported. The next falling edge arrives about 6 clocks after the stop sample, while the block is in IDLE.
- rx_rst_n asserted mid-frame clears all outputs immediately; no partial byte is delivered.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - Each sample is the 2-of-3 majority of rx_s at clockCount 13,14,15 (data/stop) or 5,6,7 (start).
  - Decision points and latency are unchanged.
- Undefined: each sample is the single value of rx_s at clockCount 15 (data/stop) or 7 (start).

## Test plan
- Frame 0xA5 with stop=1, 16 clocks/bit → rx_out=0xA5, a single rx_done pulse at E154+1, rx_err=0, rx_busy high E3–E154.
- Back-to-back 0x00 then 0xFF, no idle gap → two rx_done pulses 160 clocks apart, rx_out 0x00 then 0xFF, rx_err=0 both times.
- rx_in low for 4 clocks then high → no rx_done; rx_busy falls after E10; state returns to IDLE.
- 0x3C with stop bit low, line held low 40 clocks then high, then frame 0x55 → first rx_done with rx_err=1 and rx_out=0x3C; no frame starts while the line is low; then rx_out=0x55 with rx_err=0.
- rx_rst_n pulsed low during data bit 4 of 0x81, then a fresh 0x81 → all outputs 0 immediately and no rx_done for the aborted frame; the second frame gives rx_out=0x81.
- Frame 0xFF with a one-clock low glitch on rx_s at clockCount 15 of bit 3 → with UART_RX_MAJORITY_EN, rx_out=0xFF; without it, rx_out=0xF7.
